// File: rtl/pixie_pkg.sv
// Shared constants for the Pixie display pipeline: bus state codes, repeat-mode
// encodings and the default frame geometry used by front end, back end and frame buffer.
package pixie_pkg;

    localparam logic [1:0] SC_DMA = 2'b10;

    typedef enum logic [1:0] {
        MODE_X1     = 2'b00,
        MODE_X2     = 2'b01,
        MODE_X4     = 2'b10,
        MODE_X4_ALT = 2'b11
    } mode_e;

    localparam int DEF_TOTAL_LINES     = 262;
    localparam int DEF_FIRST_ACTIVE    = 64;
    localparam int DEF_ACTIVE_LINES    = 128;
    localparam int DEF_CYCLES_PER_LINE = 14;
    localparam int DEF_BYTES_PER_LINE  = 8;
    localparam int DEF_DMA_START_CYCLE = 2;
    localparam int DEF_INT_LINES       = 2;
    localparam int DEF_EFX_LINES       = 4;
    localparam int DEF_FB_AW           = 10;

    // log2 of the vertical repeat factor; the spare encoding behaves as x4.
    function automatic int mode_shift(input logic [1:0] m);
        case (m)
            MODE_X1: return 0;
            MODE_X2: return 1;
            default: return 2;
        endcase
    endfunction

endpackage

// File: rtl/pixie_line_counter.sv
// Machine-cycle and line counters for the Pixie timing generator.
// Counts advance only on clk_enable; frame_start marks entry to line 0, cyc 0.
module pixie_line_counter #(
    parameter int TOTAL_LINES     = 262,
    parameter int CYCLES_PER_LINE = 14,
    parameter int CW              = 4,
    parameter int LW              = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_enable,
    output logic [CW-1:0] cyc,
    output logic [LW-1:0] line,
    output logic [LW-1:0] next_line,
    output logic          wrap,
    output logic          frame_start
);

    localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLES_PER_LINE - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(TOTAL_LINES - 1);

    assign wrap      = clk_enable && (cyc == CYC_LAST);
    assign next_line = (line == LINE_LAST) ? '0 : line + LW'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc         <= '0;
            line        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= wrap && (line == LINE_LAST);
            if (wrap) begin
                cyc  <= '0;
                line <= next_line;
            end else if (clk_enable) begin
                cyc <= cyc + CW'(1);
            end
        end
    end

endmodule

// File: rtl/pixie_dma_timing_gen.sv
// CDP1861-style display timing generator: DMAO/INT/EF1 generation with line repeat,
// frame-buffer capture of DMA-out bytes, short-line detection and a frame strobe.
module pixie_dma_timing_gen
    import pixie_pkg::*;
#(
    parameter int TOTAL_LINES     = DEF_TOTAL_LINES,
    parameter int FIRST_ACTIVE    = DEF_FIRST_ACTIVE,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
    parameter int CYCLES_PER_LINE = DEF_CYCLES_PER_LINE,
    parameter int BYTES_PER_LINE  = DEF_BYTES_PER_LINE,
    parameter int DMA_START_CYCLE = DEF_DMA_START_CYCLE,
    parameter int INT_LINES       = DEF_INT_LINES,
    parameter int EFX_LINES       = DEF_EFX_LINES,
    parameter int FB_AW           = DEF_FB_AW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic [1:0]       sc,
    input  logic             disp_on,
    input  logic             disp_off,
    input  logic [7:0]       data,
    input  logic [1:0]       mode,
    output logic             dmao,
    output logic             INT,
    output logic             efx,
    output logic [FB_AW-1:0] mem_addr,
    output logic [7:0]       mem_data,
    output logic             mem_wr_en,
    output logic             frame_start,
    output logic             dma_short
);

    localparam int CW = $clog2(CYCLES_PER_LINE);
    localparam int LW = $clog2(TOTAL_LINES);
    localparam int BW = $clog2(BYTES_PER_LINE + 1);

    localparam logic [CW-1:0] DMA_SET_CYC = CW'(DMA_START_CYCLE - 1);
    localparam logic [BW-1:0] LAST_BYTE   = BW'(BYTES_PER_LINE - 1);
    localparam logic [31:0]   ACT_LO      = 32'(FIRST_ACTIVE);
    localparam logic [31:0]   ACT_HI      = 32'(FIRST_ACTIVE + ACTIVE_LINES);
    localparam logic [31:0]   INT_LO      = 32'(FIRST_ACTIVE - INT_LINES);
    localparam logic [31:0]   EFX_LO      = 32'(FIRST_ACTIVE - EFX_LINES);
    localparam logic [31:0]   EFX_END_LO  = 32'(FIRST_ACTIVE + ACTIVE_LINES - EFX_LINES);

    if (DMA_START_CYCLE < 1 || DMA_START_CYCLE + BYTES_PER_LINE > CYCLES_PER_LINE) begin : g_bad_dma
        $error("DMA window does not fit inside a line");
    end
    if (ACTIVE_LINES * BYTES_PER_LINE > (1 << FB_AW)) begin : g_bad_fb
        $error("frame buffer too small for the active area");
    end
    if (FIRST_ACTIVE < INT_LINES || FIRST_ACTIVE < EFX_LINES) begin : g_bad_first
        $error("FIRST_ACTIVE leaves no room for INT/EFX lines");
    end
    if (FIRST_ACTIVE + ACTIVE_LINES > TOTAL_LINES) begin : g_bad_total
        $error("active area runs past the end of the frame");
    end

    logic [CW-1:0]    cyc;
    logic [LW-1:0]    line, next_line;
    logic             wrap;
    logic             disp_en, disp_en_next, line_en;
    logic             dma_active, last_wr, fetch;
    logic             next_active, int_next, efx_next;
    logic [1:0]       mode_l, mode_next;
    logic [BW-1:0]    byte_cnt;
    logic [FB_AW-1:0] row_base, row_base_next;
    logic [31:0]      line_w, rel, next_w, next_rel;
    int               sh, sh_next;

    pixie_line_counter #(
        .TOTAL_LINES    (TOTAL_LINES),
        .CYCLES_PER_LINE(CYCLES_PER_LINE),
        .CW             (CW),
        .LW             (LW)
    ) u_line_counter (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .cyc        (cyc),
        .line       (line),
        .next_line  (next_line),
        .wrap       (wrap),
        .frame_start(frame_start)
    );

    always_comb begin
        disp_en_next = disp_en;
        if (disp_off)
            disp_en_next = 1'b0;
        else if (disp_on)
            disp_en_next = 1'b1;
    end

    assign line_w = 32'(line);
    assign rel    = line_w - ACT_LO;
    assign sh     = mode_shift(mode_l);
    assign fetch  = line_en && (line_w >= ACT_LO) && (line_w < ACT_HI)
                    && ((rel & ((32'd1 << sh) - 32'd1)) == 32'd0);

    // Per-line state is prepared on the tick that enters the next line, so the
    // flags and row base are already valid for the whole of that line.
    assign next_w        = 32'(next_line);
    assign next_rel      = next_w - ACT_LO;
    assign next_active   = (next_w >= ACT_LO) && (next_w < ACT_HI);
    assign int_next      = (next_w >= INT_LO) && (next_w < ACT_LO);
    assign efx_next      = ((next_w >= EFX_LO) && (next_w < ACT_LO))
                           || ((next_w >= EFX_END_LO) && (next_w < ACT_HI));
    assign mode_next     = (next_line == '0) ? mode : mode_l;
    assign sh_next       = mode_shift(mode_next);
    assign row_base_next = next_active ? FB_AW'((next_rel >> sh_next) * 32'(BYTES_PER_LINE)) : '0;

    assign dmao      = dma_active;
    assign mem_wr_en = clk_enable && dma_active && (sc == SC_DMA);
    assign mem_data  = reset ? data : 8'h00;
    assign mem_addr  = row_base + FB_AW'(byte_cnt);
    assign last_wr   = mem_wr_en && (byte_cnt == LAST_BYTE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_en    <= 1'b0;
            line_en    <= 1'b0;
            mode_l     <= MODE_X1;
            dma_active <= 1'b0;
            byte_cnt   <= '0;
            row_base   <= '0;
            dma_short  <= 1'b0;
            INT        <= 1'b0;
            efx        <= 1'b0;
        end else begin
            dma_short <= 1'b0;
            if (clk_enable) begin
                disp_en <= disp_en_next;
                if (cyc == DMA_SET_CYC && fetch)
                    dma_active <= 1'b1;
                else if (wrap || last_wr)
                    dma_active <= 1'b0;
                dma_short <= wrap && dma_active && !last_wr;
                if (cyc == '0)
                    byte_cnt <= '0;
                else if (mem_wr_en)
                    byte_cnt <= byte_cnt + BW'(1);
                if (wrap) begin
                    line_en  <= disp_en_next;
                    INT      <= int_next && disp_en_next;
                    efx      <= efx_next;
                    row_base <= row_base_next;
                    mode_l   <= mode_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixie_dma_timing_gen.sv
// Bench for pixie_dma_timing_gen: frame-level reference model driven by tick position,
// directed frames for enable/mode/short-line/reset cases with randomized data and bus codes.
module tb_pixie_dma_timing_gen;

    localparam int TL = 262, FA = 64, AL = 128, CPL = 14, BPL = 8, DSC = 2;
    localparam int INTL = 2, EFXL = 4, AW = 10;
    localparam int FRAME = TL * CPL;

    logic          clk = 1'b0, reset = 1'b0, clk_enable = 1'b0, disp_on = 1'b0, disp_off = 1'b0;
    logic [1:0]    sc = 2'b00, mode = 2'b00;
    logic [7:0]    data = 8'h00;
    logic          dmao, INT, efx, mem_wr_en, frame_start, dma_short;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;

    int checks = 0, errors = 0;

    // reference model: position is the number of ticks since reset
    int t, nb, shift_m;
    bit disp_en_m, line_en_m, int_m, fs_m, short_m;
    int bursts, writes, shorts, fs_cnt, int_clks, efx_clks, max_addr;
    bit prev_dmao;

    always #5 clk = ~clk;

    pixie_dma_timing_gen #(
        .TOTAL_LINES(TL), .FIRST_ACTIVE(FA), .ACTIVE_LINES(AL), .CYCLES_PER_LINE(CPL),
        .BYTES_PER_LINE(BPL), .DMA_START_CYCLE(DSC), .INT_LINES(INTL), .EFX_LINES(EFXL), .FB_AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .sc(sc), .disp_on(disp_on),
        .disp_off(disp_off), .data(data), .mode(mode), .dmao(dmao), .INT(INT), .efx(efx),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_wr_en(mem_wr_en),
        .frame_start(frame_start), .dma_short(dma_short)
    );

    function automatic int m_line();
        return (t / CPL) % TL;
    endfunction

    function automatic int m_cyc();
        return t % CPL;
    endfunction

    function automatic bit efx_line(input int ln);
        return (ln >= FA - EFXL && ln < FA) || (ln >= FA + AL - EFXL && ln < FA + AL);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (line %0d cyc %0d)", tag, got, exp, m_line(), m_cyc());
        end
    endtask

    task automatic model_reset();
        t = 0; nb = 0; shift_m = 0;
        disp_en_m = 0; line_en_m = 0; int_m = 0; fs_m = 0; short_m = 0;
    endtask

    task automatic clear_stats();
        bursts = 0; writes = 0; shorts = 0; fs_cnt = 0; int_clks = 0; efx_clks = 0;
        max_addr = -1; prev_dmao = 0;
    endtask

    // One clk: drive inputs, check outputs at the falling edge, then advance the model.
    task automatic clk1(input bit ce, input logic [1:0] s, input bit on, input bit off,
                        input logic [7:0] d, input logic [1:0] md);
        int ln, cy, rr;
        bit fetch, edma, ewr;
        clk_enable = ce; sc = s; disp_on = on; disp_off = off; data = d; mode = md;
        @(negedge clk);
        ln = m_line(); cy = m_cyc(); rr = 1 << shift_m;
        fetch = line_en_m && ln >= FA && ln < FA + AL && ((ln - FA) % rr == 0);
        edma  = fetch && cy >= DSC && nb < BPL;
        ewr   = ce && edma && s == 2'b10;
        chk("dmao", dmao, edma);
        chk("mem_wr_en", mem_wr_en, ewr);
        chk("INT", INT, int_m);
        chk("efx", efx, efx_line(ln));
        chk("frame_start", frame_start, fs_m);
        chk("dma_short", dma_short, short_m);
        if (ewr) begin
            chk("mem_addr", mem_addr, ((ln - FA) / rr) * BPL + nb);
            chk("mem_data", mem_data, d);
        end
        if (dmao && !prev_dmao) bursts++;
        prev_dmao = dmao;
        if (mem_wr_en) begin
            writes++;
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        end
        shorts += int'(dma_short); fs_cnt += int'(frame_start);
        int_clks += int'(INT); efx_clks += int'(efx);
        fs_m = 0; short_m = 0;
        if (ce) begin
            if (off) disp_en_m = 0;
            else if (on) disp_en_m = 1;
            if (ewr) nb++;
            if (cy == CPL - 1 && edma && nb < BPL) short_m = 1;
            t++;
            if (m_cyc() == 0) begin
                nb = 0;
                ln = m_line();
                line_en_m = disp_en_m;
                int_m = ln >= FA - INTL && ln < FA && disp_en_m;
                if (ln == 0) begin
                    fs_m = 1;
                    shift_m = (md == 2'b00) ? 0 : (md == 2'b01) ? 1 : 2;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int ln, cy;
        model_reset();
        clk_enable = 1; sc = 2'b10; data = 8'hA5;
        #3;
        chk("rst_dmao", dmao, 0); chk("rst_INT", INT, 0); chk("rst_efx", efx, 0);
        chk("rst_wr", mem_wr_en, 0); chk("rst_fs", frame_start, 0); chk("rst_short", dma_short, 0);
        chk("rst_addr", mem_addr, 0); chk("rst_data", mem_data, 0);
        @(posedge clk); #1 reset = 1;

        // frame 0: display disabled
        clear_stats();
        while (t < FRAME) clk1(1, 2'($urandom), 0, 0, 8'($urandom), 2'b00);
        chk("f0_bursts", bursts, 0); chk("f0_int", int_clks, 0);
        chk("f0_efx", efx_clks, 8 * CPL); chk("f0_fs", fs_cnt, 0);

        // frame 1: x1, sc withheld after 5 bytes on line 64, x2 selected before the wrap
        clear_stats();
        while (t < 2 * FRAME) begin
            ln = m_line(); cy = m_cyc();
            clk1(1, (ln == FA && nb >= 5) ? 2'b01 : 2'b10, t == FRAME + 20, 0,
                 8'($urandom), (ln >= 250) ? 2'b01 : 2'b00);
        end
        chk("f1_fs", fs_cnt, 1); chk("f1_bursts", bursts, 128); chk("f1_writes", writes, 1021);
        chk("f1_shorts", shorts, 1); chk("f1_maxaddr", max_addr, 1023); chk("f1_int", int_clks, 2 * CPL);

        // frame 2: x2 with clock-enable gaps, mode switched to x4 at line 120
        clear_stats();
        while (t < 3 * FRAME) begin
            ln = m_line();
            clk1($urandom_range(0, 3) != 0, 2'b10, 0, 0, 8'($urandom), (ln >= 120) ? 2'b10 : 2'b01);
        end
        chk("f2_fs", fs_cnt, 1); chk("f2_bursts", bursts, 64); chk("f2_writes", writes, 512);
        chk("f2_maxaddr", max_addr, 511); chk("f2_shorts", shorts, 0);

        // frame 3: x4, random bus codes, disable at 100/5, on+off at 110/3, enable at 150/0
        clear_stats();
        while (t < 4 * FRAME) begin
            ln = m_line(); cy = m_cyc();
            clk1(1, ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom),
                 (ln == 110 && cy == 3) || (ln == 150 && cy == 0),
                 (ln == 100 && cy == 5) || (ln == 110 && cy == 3),
                 8'($urandom), (ln >= 200) ? 2'b00 : 2'b10);
        end
        chk("f3_fs", fs_cnt, 1); chk("f3_bursts", bursts, 20);
        chk("f3_int", int_clks, 2 * CPL); chk("f3_efx", efx_clks, 8 * CPL);

        // frame 4: x1 burst, asynchronous reset at line 189 cyc 5
        clear_stats();
        while (t < 4 * FRAME + 189 * CPL + 5) clk1(1, 2'b10, 0, 0, 8'($urandom), 2'b00);
        clk_enable = 1; sc = 2'b10; data = 8'h3C;
        @(negedge clk);
        chk("pre_rst_dmao", dmao, 1); chk("pre_rst_wr", mem_wr_en, 1); chk("pre_rst_efx", efx, 1);
        #1 reset = 0;
        #1;
        chk("arst_dmao", dmao, 0); chk("arst_wr", mem_wr_en, 0); chk("arst_efx", efx, 0);
        chk("arst_INT", INT, 0); chk("arst_addr", mem_addr, 0); chk("arst_data", mem_data, 0);
        @(posedge clk); @(posedge clk); #1 reset = 1;
        model_reset();
        clear_stats();
        while (t < 70 * CPL) clk1(1, 2'b10, 0, 0, 8'($urandom), 2'($urandom));
        chk("post_bursts", bursts, 0); chk("post_writes", writes, 0);
        chk("post_fs", fs_cnt, 0); chk("post_int", int_clks, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
